// File: rtl/serial_rx_pkg.sv
// serial_rx_pkg: shared types and default constants for the serial frame receiver.
//   rx_state_t          : receiver state (HUNT while searching for sync, LOCKED while deserialising)
//   RX_WIDTH_DEF        : default word / sync pattern width
//   RX_SYNC_DEF         : default sync pattern
//   RX_FRAME_WORDS_DEF  : default payload words per frame
package serial_rx_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } rx_state_t;

    localparam int unsigned RX_WIDTH_DEF       = 8;
    localparam logic [7:0]  RX_SYNC_DEF        = 8'hA5;
    localparam int unsigned RX_FRAME_WORDS_DEF = 4;

endpackage

// File: rtl/serial_shift_reg.sv
// serial_shift_reg: WIDTH-bit left-shift register, new bit enters at the LSB.
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (clears the register)
//   en     in   shift enable
//   clr    in   synchronous clear, wins over en
//   din    in   serial bit inserted at the LSB
//   q      out  parallel register contents
module serial_shift_reg
    import serial_rx_pkg::*;
#(
    parameter int unsigned WIDTH = RX_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // Next register value: clear, shift or hold
    always_comb begin
        sr_d = sr_q;
        if (clr) begin
            sr_d = '0;
        end else if (en) begin
            sr_d = (sr_q << 1) | WIDTH'(din);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q = sr_q;

endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: hunts for SYNC_PATTERN in a qualified serial stream, then
// deserialises FRAME_WORDS MSB-first words and returns to hunting.
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   din         in   serial bit
//   din_en      in   bit qualifier; din sampled only when 1
//   data_out    out  last completed word (registered, held)
//   data_valid  out  one-cycle strobe, data_out is new
//   sync_found  out  one-cycle strobe on sync match while hunting
//   locked      out  high while a frame is being received
//   parity_err  out  even-parity error, valid with data_valid
//                    (port exists only when SERIAL_RX_PARITY_EN is defined)
// Build option: SERIAL_RX_PARITY_EN adds a trailing even-parity bit per word.
module serial_frame_rx
    import serial_rx_pkg::*;
#(
    parameter int unsigned      WIDTH        = RX_WIDTH_DEF,
    parameter logic [WIDTH-1:0] SYNC_PATTERN = WIDTH'(RX_SYNC_DEF),
    parameter int unsigned      FRAME_WORDS  = RX_FRAME_WORDS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_en,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             sync_found,
    output logic             locked
`ifdef SERIAL_RX_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int unsigned BCW = $clog2(WIDTH + 1);
    localparam int unsigned WCW = $clog2(FRAME_WORDS + 1);
`ifdef SERIAL_RX_PARITY_EN
    // Bit index WIDTH is the parity bit that closes the word
    localparam int unsigned LAST_BIT = WIDTH;
`else
    localparam int unsigned LAST_BIT = WIDTH - 1;
`endif

    rx_state_t        state_q, state_d;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] shifted_c;
    logic             sr_en;
    logic             sr_clr;
    logic             sync_hit_c;
    logic             word_done_c;
    logic             frame_done_c;

    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WCW-1:0]   word_cnt_q, word_cnt_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             sync_found_q, sync_found_d;
    logic             locked_q, locked_d;
`ifdef SERIAL_RX_PARITY_EN
    logic             parity_err_q, parity_err_d;
`endif

    // Shift register value including the bit sampled on this edge
    assign shifted_c    = (sr_q << 1) | WIDTH'(din);
    assign sync_hit_c   = din_en && (state_q == HUNT) && (shifted_c == SYNC_PATTERN);
    assign word_done_c  = din_en && (state_q == LOCKED) && (bit_cnt_q == BCW'(LAST_BIT));
    assign frame_done_c = word_done_c && (word_cnt_q == WCW'(FRAME_WORDS - 1));

`ifdef SERIAL_RX_PARITY_EN
    // The parity bit is consumed by the counter but kept out of the word
    assign sr_en = din_en && !word_done_c;
`else
    assign sr_en = din_en;
`endif
    // Clearing at frame end forces a full fresh sync window
    assign sr_clr = frame_done_c;

    serial_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk   (clk),
        .rst_n (reset),
        .en    (sr_en),
        .clr   (sr_clr),
        .din   (din),
        .q     (sr_q)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            HUNT:    if (sync_hit_c)   state_d = LOCKED;
            LOCKED:  if (frame_done_c) state_d = HUNT;
            default: state_d = HUNT;
        endcase
    end

    // Counter and output next values
    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        sync_found_d = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        parity_err_d = 1'b0;
`endif
        if (sync_hit_c) begin
            sync_found_d = 1'b1;
            bit_cnt_d    = '0;
            word_cnt_d   = '0;
        end else if (din_en && (state_q == LOCKED)) begin
            if (word_done_c) begin
                data_valid_d = 1'b1;
                bit_cnt_d    = '0;
                word_cnt_d   = word_cnt_q + WCW'(1);
`ifdef SERIAL_RX_PARITY_EN
                data_out_d   = sr_q;
                parity_err_d = ^{sr_q, din};
`else
                data_out_d   = shifted_c;
`endif
            end else begin
                bit_cnt_d = bit_cnt_q + BCW'(1);
            end
        end
        locked_d = (state_d == LOCKED);
    end

    // Counter and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            sync_found_q <= 1'b0;
            locked_q     <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            sync_found_q <= sync_found_d;
            locked_q     <= locked_d;
`ifdef SERIAL_RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign sync_found = sync_found_q;
    assign locked     = locked_q;
`ifdef SERIAL_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: scoreboard bench for serial_frame_rx (8-bit, sync 0xA5, 4 words).
// Expected words (with expected parity error flag) are queued when driven; a
// monitor queues each data_valid word, and each test task compares the queues.
// Build option: SERIAL_RX_PARITY_EN adds a parity bit per driven word and a parity test.
module tb_serial_frame_rx;

`ifdef SERIAL_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       din;
    logic       din_en;
    logic [7:0] data_out;
    logic       data_valid;
    logic       sync_found;
    logic       locked;
    logic       perr_w;
`ifdef SERIAL_RX_PARITY_EN
    logic       parity_err;
    assign perr_w = parity_err;
`else
    assign perr_w = 1'b0;
`endif

    int checks = 0;
    int passes = 0;
    int n_sync = 0;
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];

    serial_frame_rx #(
        .WIDTH        (8),
        .SYNC_PATTERN (8'hA5),
        .FRAME_WORDS  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_en     (din_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .sync_found (sync_found),
        .locked     (locked)
`ifdef SERIAL_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: collect every completed word with its parity flag
    always @(posedge clk) begin
        #1;
        if (data_valid === 1'b1) got_q.push_back({perr_w, data_out});
        if (sync_found === 1'b1) n_sync++;
    end

    // Drive one bit on the falling edge; return shortly after the next rising edge
    task automatic step(input logic b, input logic en);
        @(negedge clk);
        din    = b;
        din_en = en;
        @(posedge clk);
        #2;
    endtask

    // Raw bits, MSB first; with toggle an idle cycle precedes every qualified bit
    task automatic send_bits(input logic [7:0] w, input bit toggle);
        for (int i = 7; i >= 0; i--) begin
            if (toggle) step(1'b0, 1'b0);
            step(w[i], 1'b1);
        end
    endtask

    // Payload word: bits, parity bit in parity builds, and its scoreboard entry
    task automatic send_word(input logic [7:0] w, input bit toggle, input bit bad_par);
        exp_q.push_back({bad_par & PAR_EN, w});
        send_bits(w, toggle);
`ifdef SERIAL_RX_PARITY_EN
        if (toggle) step(1'b0, 1'b0);
        step((^w) ^ bad_par, 1'b1);
`endif
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        din    = 1'b0;
        din_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (data_out !== 8'h00) $display("FAIL reset_data_out: got %h expected 00", data_out); else passes++;
        checks++; if (data_valid !== 1'b0) $display("FAIL reset_data_valid: got %b expected 0", data_valid); else passes++;
        checks++; if (sync_found !== 1'b0) $display("FAIL reset_sync_found: got %b expected 0", sync_found); else passes++;
        checks++; if (locked !== 1'b0) $display("FAIL reset_locked: got %b expected 0", locked); else passes++;
        checks++; if (perr_w !== 1'b0) $display("FAIL reset_parity_err: got %b expected 0", perr_w); else passes++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_sync();
        n_sync = 0;
        send_bits(8'hA5, 1'b0);
        checks++; if (sync_found !== 1'b1) $display("FAIL sync_strobe: got %b expected 1", sync_found); else passes++;
        checks++; if (locked !== 1'b1) $display("FAIL sync_locked: got %b expected 1", locked); else passes++;
        checks++; if (data_valid !== 1'b0) $display("FAIL sync_no_valid: got %b expected 0", data_valid); else passes++;
        step(1'b0, 1'b0);
        checks++; if (sync_found !== 1'b0) $display("FAIL sync_one_cycle: got %b expected 0", sync_found); else passes++;
        checks++; if (locked !== 1'b1) $display("FAIL sync_lock_held: got %b expected 1", locked); else passes++;
        checks++; if (n_sync !== 1) $display("FAIL sync_count: got %0d expected 1", n_sync); else passes++;
    endtask

    // Continues the frame opened by test_sync
    task automatic test_frame();
        logic [8:0] g, e;
        n_sync = 0;
        send_word(8'h3C, 1'b0, 1'b0);
        send_word(8'hA5, 1'b0, 1'b0);
        send_word(8'hFF, 1'b0, 1'b0);
        checks++; if (locked !== 1'b1) $display("FAIL frame_locked_mid: got %b expected 1", locked); else passes++;
        send_word(8'h00, 1'b0, 1'b0);
        checks++; if (data_valid !== 1'b1) $display("FAIL frame_last_valid: got %b expected 1", data_valid); else passes++;
        checks++; if (locked !== 1'b0) $display("FAIL frame_unlock: got %b expected 0", locked); else passes++;
        checks++; if (n_sync !== 0) $display("FAIL frame_payload_sync: got %0d expected 0", n_sync); else passes++;
        checks++; if (got_q.size() != exp_q.size()) $display("FAIL frame_count: got %0d expected %0d", got_q.size(), exp_q.size()); else passes++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++; if (g !== e) $display("FAIL frame_word: got %h expected %h", g, e); else passes++;
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_din_en_toggle();
        logic [8:0] g, e;
        send_bits(8'hA5, 1'b1);
        checks++; if (sync_found !== 1'b1) $display("FAIL toggle_sync: got %b expected 1", sync_found); else passes++;
        send_word(8'h3C, 1'b1, 1'b0);
        checks++; if (data_valid !== 1'b1) $display("FAIL toggle_valid: got %b expected 1", data_valid); else passes++;
        checks++; if (data_out !== 8'h3C) $display("FAIL toggle_data: got %h expected 3c", data_out); else passes++;
        step(1'b1, 1'b0);
        checks++; if (data_valid !== 1'b0) $display("FAIL toggle_valid_drop: got %b expected 0", data_valid); else passes++;
        checks++; if (data_out !== 8'h3C) $display("FAIL toggle_data_hold: got %h expected 3c", data_out); else passes++;
        send_word(8'h01, 1'b0, 1'b0);
        send_word(8'h02, 1'b0, 1'b0);
        send_word(8'h03, 1'b0, 1'b0);
        checks++; if (locked !== 1'b0) $display("FAIL toggle_unlock: got %b expected 0", locked); else passes++;
        checks++; if (got_q.size() != exp_q.size()) $display("FAIL toggle_count: got %0d expected %0d", got_q.size(), exp_q.size()); else passes++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++; if (g !== e) $display("FAIL toggle_word: got %h expected %h", g, e); else passes++;
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid_frame();
        logic [8:0] g, e;
        logic [7:0] partial;
        partial = 8'h22;
        send_bits(8'hA5, 1'b0);
        send_word(8'h11, 1'b0, 1'b0);
        for (int i = 7; i >= 3; i--) step(partial[i], 1'b1);
        @(negedge clk);
        reset  = 1'b0;
        din_en = 1'b0;
        #1;
        checks++; if (data_out !== 8'h00) $display("FAIL rst_mid_data_out: got %h expected 00", data_out); else passes++;
        checks++; if (locked !== 1'b0) $display("FAIL rst_mid_locked: got %b expected 0", locked); else passes++;
        checks++; if (data_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b expected 0", data_valid); else passes++;
        checks++; if (sync_found !== 1'b0) $display("FAIL rst_mid_sync: got %b expected 0", sync_found); else passes++;
        @(negedge clk);
        reset = 1'b1;
        send_bits(8'hA5, 1'b0);
        checks++; if (sync_found !== 1'b1) $display("FAIL rst_resync: got %b expected 1", sync_found); else passes++;
        send_word(8'h12, 1'b0, 1'b0);
        checks++; if (data_out !== 8'h12) $display("FAIL rst_first_word: got %h expected 12", data_out); else passes++;
        send_word(8'h13, 1'b0, 1'b0);
        send_word(8'h14, 1'b0, 1'b0);
        send_word(8'h15, 1'b0, 1'b0);
        checks++; if (got_q.size() != exp_q.size()) $display("FAIL rst_count: got %0d expected %0d", got_q.size(), exp_q.size()); else passes++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++; if (g !== e) $display("FAIL rst_word: got %h expected %h", g, e); else passes++;
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // Stream that contains no 0xA5 window anywhere
    task automatic test_no_sync();
        n_sync = 0;
        send_bits(8'h5A, 1'b0);
        send_bits(8'hC3, 1'b0);
        send_bits(8'h00, 1'b0);
        checks++; if (n_sync !== 0) $display("FAIL nosync_sync: got %0d expected 0", n_sync); else passes++;
        checks++; if (locked !== 1'b0) $display("FAIL nosync_locked: got %b expected 0", locked); else passes++;
        checks++; if (got_q.size() != 0) $display("FAIL nosync_valid: got %0d words expected 0", got_q.size()); else passes++;
        got_q.delete();
    endtask

`ifdef SERIAL_RX_PARITY_EN
    task automatic test_parity();
        logic [8:0] g, e;
        send_bits(8'hA5, 1'b0);
        send_word(8'h3C, 1'b0, 1'b0);
        checks++; if (data_valid !== 1'b1) $display("FAIL par_good_valid: got %b expected 1", data_valid); else passes++;
        checks++; if (parity_err !== 1'b0) $display("FAIL par_good_err: got %b expected 0", parity_err); else passes++;
        send_word(8'h3C, 1'b0, 1'b1);
        checks++; if (data_valid !== 1'b1) $display("FAIL par_bad_valid: got %b expected 1", data_valid); else passes++;
        checks++; if (parity_err !== 1'b1) $display("FAIL par_bad_err: got %b expected 1", parity_err); else passes++;
        checks++; if (data_out !== 8'h3C) $display("FAIL par_bad_data: got %h expected 3c", data_out); else passes++;
        step(1'b0, 1'b0);
        checks++; if (parity_err !== 1'b0) $display("FAIL par_err_drop: got %b expected 0", parity_err); else passes++;
        send_word(8'h01, 1'b0, 1'b0);
        send_word(8'h02, 1'b0, 1'b0);
        checks++; if (got_q.size() != exp_q.size()) $display("FAIL par_count: got %0d expected %0d", got_q.size(), exp_q.size()); else passes++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++; if (g !== e) $display("FAIL par_word: got %h expected %h", g, e); else passes++;
        end
        got_q.delete();
        exp_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_sync();
        test_frame();
        test_din_en_toggle();
        test_reset_mid_frame();
        test_no_sync();
`ifdef SERIAL_RX_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
